// File: rtl/imem_boot_loader.sv
// Boot loader: holds the core in reset while host words stream into consecutive imem words.
// Define LOADER_CHECKSUM_EN to require a trailing checksum word that brings the word sum to zero.
module imem_boot_loader #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_start,
   input  logic [ADDR_W:0]   load_len,
   input  logic              s_valid,
   input  logic [31:0]       s_data,
   output logic              s_ready,
   output logic              imem_we,
   output logic [31:0]       imem_addr,
   output logic [31:0]       imem_wd,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] LEN_ONE   = {{ADDR_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;

   state_t              state_reg, state_next;
   logic [ADDR_W:0]     len_reg, len_next;
   logic [ADDR_W:0]     cnt_reg, cnt_next;
   logic                we_reg, we_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic [31:0]         wd_reg, wd_next;
   logic                err_reg, err_next;
   logic                ready;
   logic                hs;
   logic                len_valid;

`ifdef LOADER_CHECKSUM_EN
   logic [31:0]         sum_reg, sum_next;
   logic [31:0]         sum_total;

   assign sum_total = sum_reg + s_data;
`endif

   assign ready     = (state_reg == LOAD);
   assign hs        = s_valid && ready;
   assign len_valid = (load_len != '0) && (load_len <= MAX_WORDS);

   assign s_ready   = ready;
   assign imem_we   = we_reg;
   assign imem_addr = {{(30 - ADDR_W){1'b0}}, addr_reg, 2'b00};
   assign imem_wd   = wd_reg;
   assign cpu_reset = (state_reg != RUN);
   assign busy      = (state_reg == LOAD) || (state_reg == FLUSH);
   assign done      = (state_reg == RUN);
   assign err       = err_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         len_reg   <= '0;
         cnt_reg   <= '0;
         we_reg    <= 1'b0;
         addr_reg  <= '0;
         wd_reg    <= '0;
         err_reg   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum_reg   <= '0;
`endif
      end else begin
         state_reg <= state_next;
         len_reg   <= len_next;
         cnt_reg   <= cnt_next;
         we_reg    <= we_next;
         addr_reg  <= addr_next;
         wd_reg    <= wd_next;
         err_reg   <= err_next;
`ifdef LOADER_CHECKSUM_EN
         sum_reg   <= sum_next;
`endif
      end
   end

   always_comb begin
      state_next = state_reg;
      len_next   = len_reg;
      cnt_next   = cnt_reg;
      we_next    = 1'b0;
      addr_next  = addr_reg;
      wd_next    = wd_reg;
      err_next   = err_reg;
`ifdef LOADER_CHECKSUM_EN
      sum_next   = sum_reg;
`endif

      case (state_reg)
         // RUN shares the IDLE acceptance rules; leaving RUN re-asserts cpu_reset
         IDLE, RUN: begin
            if (load_start) begin
               if (len_valid) begin
                  state_next = LOAD;
                  len_next   = load_len;
                  cnt_next   = '0;
                  err_next   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                  sum_next   = '0;
`endif
               end else begin
                  state_next = IDLE;
                  err_next   = 1'b1;
               end
            end
         end

         LOAD: begin
            if (hs) begin
`ifdef LOADER_CHECKSUM_EN
               if (cnt_reg == len_reg) begin
                  // checksum word: never written, only judged
                  if (sum_total == 32'd0) begin
                     state_next = FLUSH;
                  end else begin
                     state_next = IDLE;
                     err_next   = 1'b1;
                  end
               end else begin
                  we_next   = 1'b1;
                  addr_next = cnt_reg[ADDR_W-1:0];
                  wd_next   = s_data;
                  cnt_next  = cnt_reg + LEN_ONE;
                  sum_next  = sum_total;
               end
`else
               we_next   = 1'b1;
               addr_next = cnt_reg[ADDR_W-1:0];
               wd_next   = s_data;
               cnt_next  = cnt_reg + LEN_ONE;
               if (cnt_reg == len_reg - LEN_ONE) begin
                  state_next = FLUSH;
               end
`endif
            end
         end

         FLUSH: begin
            state_next = RUN;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule
